// File: rtl/fixed_patch_unembed_pkg.sv
// Shared sizing helpers and the write-counter record for the patch unembed block.
package fixed_patch_unembed_pkg;

    // Width of each write-side counter field. It must hold max(NPX, PATCH, CB) - 1.
    localparam int CNT_W = 8;

    function automatic int calc_cb(input int c, input int unroll_c);
        return c / unroll_c;
    endfunction

    function automatic int calc_np(input int img, input int patch);
        return img / patch;
    endfunction

    function automatic int calc_row_beats(input int patch, input int img_x, input int cb);
        return patch * img_x * cb;
    endfunction

    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic [CNT_W-1:0] px;
        logic [CNT_W-1:0] ky;
        logic [CNT_W-1:0] kx;
        logic [CNT_W-1:0] cb;
    } wr_cnt_t;

endpackage

// File: rtl/fixed_patch_unembed_buffer.sv
// Two-bank row store: one synchronous write port and one combinational read port, each with its own bank select.
module patch_row_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int UNROLL_C   = 2,
    parameter int DEPTH      = 32,
    parameter int AW         = 5
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  wr_bank_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i [UNROLL_C],
    input  logic                  rd_bank_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o [UNROLL_C]
);

    // Contents are deliberately left unreset; only the control path needs a known state.
    logic [DATA_WIDTH-1:0] mem_q [2][DEPTH][UNROLL_C];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int e = 0; e < UNROLL_C; e++) begin
                mem_q[wr_bank_i][wr_addr_i][e] <= wr_data_i[e];
            end
        end
    end

    always_comb begin
        for (int e = 0; e < UNROLL_C; e++) begin
            rd_data_o[e] = mem_q[rd_bank_i][rd_addr_i][e];
        end
    end

endmodule

// File: rtl/fixed_patch_unembed.sv
// Unpatchify: reorders patch-major (ky,kx,c) token beats into raster (y,x,c) beats through a ping-pong row buffer.
// Defining PATCH_UNEMBED_LAST_EN adds a data_out_last port that marks the final raster beat of each image.
module fixed_patch_unembed
    import fixed_patch_unembed_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int C          = 4,
    parameter int IMG_Y      = 8,
    parameter int IMG_X      = 8,
    parameter int PATCH      = 2,
    parameter int UNROLL_C   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [UNROLL_C],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [UNROLL_C],
    output logic                  data_out_valid,
`ifdef PATCH_UNEMBED_LAST_EN
    output logic                  data_out_last,
`endif
    input  logic                  data_out_ready
);

    localparam int CB        = calc_cb(C, UNROLL_C);
    localparam int NPX       = calc_np(IMG_X, PATCH);
    localparam int ROW_BEATS = calc_row_beats(PATCH, IMG_X, CB);
    localparam int AW        = calc_addr_w(ROW_BEATS);

    localparam logic [CNT_W-1:0] CB_MAX  = CNT_W'(CB - 1);
    localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(PATCH - 1);
    localparam logic [CNT_W-1:0] NPX_MAX = CNT_W'(NPX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [AW-1:0]    RD_MAX  = AW'(ROW_BEATS - 1);
    localparam logic [AW-1:0]    RD_ONE  = AW'(1);

    wr_cnt_t        wc_q, wc_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [1:0]     full_q, full_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;

    logic           wr_ok_s, rd_valid_s;
    logic           wr_fire_s, rd_fire_s;
    logic           wr_last_s, rd_last_s;
    logic [1:0]     full_set_s, full_clr_s;
    logic [AW-1:0]  wr_addr_s;

    always_comb begin
        wr_ok_s    = !full_q[wr_bank_q];
        rd_valid_s = full_q[rd_bank_q];
        wr_fire_s  = data_in_valid && wr_ok_s;
        rd_fire_s  = rd_valid_s && data_out_ready;
        wr_last_s  = (wc_q.px == NPX_MAX) && (wc_q.ky == P_MAX) &&
                     (wc_q.kx == P_MAX) && (wc_q.cb == CB_MAX);
        rd_last_s  = (rd_addr_q == RD_MAX);
        wr_addr_s  = AW'((int'(wc_q.ky) * IMG_X + int'(wc_q.px) * PATCH + int'(wc_q.kx)) * CB
                         + int'(wc_q.cb));
    end

    always_comb begin
        data_in_ready  = wr_ok_s;
        data_out_valid = rd_valid_s;
    end

    // Write cursor walks cb, kx, ky, px (innermost first) and flips bank at the end of a patch row.
    always_comb begin
        wc_d      = wc_q;
        wr_bank_d = wr_bank_q;
        if (wr_fire_s) begin
            if (wr_last_s) begin
                wc_d      = '0;
                wr_bank_d = ~wr_bank_q;
            end else if (wc_q.cb != CB_MAX) begin
                wc_d.cb = wc_q.cb + CNT_ONE;
            end else begin
                wc_d.cb = '0;
                if (wc_q.kx != P_MAX) begin
                    wc_d.kx = wc_q.kx + CNT_ONE;
                end else begin
                    wc_d.kx = '0;
                    if (wc_q.ky != P_MAX) begin
                        wc_d.ky = wc_q.ky + CNT_ONE;
                    end else begin
                        wc_d.ky = '0;
                        wc_d.px = wc_q.px + CNT_ONE;
                    end
                end
            end
        end else begin
            wc_d      = wc_q;
            wr_bank_d = wr_bank_q;
        end
    end

    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        if (rd_fire_s) begin
            if (rd_last_s) begin
                rd_addr_d = '0;
                rd_bank_d = ~rd_bank_q;
            end else begin
                rd_addr_d = rd_addr_q + RD_ONE;
            end
        end else begin
            rd_addr_d = rd_addr_q;
            rd_bank_d = rd_bank_q;
        end
    end

    // Set requires the bank empty and clear requires it full, so both never hit the same bank at once.
    always_comb begin
        full_set_s = (wr_fire_s && wr_last_s) ? (2'b01 << wr_bank_q) : 2'b00;
        full_clr_s = (rd_fire_s && rd_last_s) ? (2'b01 << rd_bank_q) : 2'b00;
        full_d     = (full_q | full_set_s) & ~full_clr_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wc_q      <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            rd_addr_q <= '0;
        end else begin
            wc_q      <= wc_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            rd_addr_q <= rd_addr_d;
        end
    end

`ifdef PATCH_UNEMBED_LAST_EN
    localparam int               NPY     = calc_np(IMG_Y, PATCH);
    localparam logic [CNT_W-1:0] NPY_MAX = CNT_W'(NPY - 1);

    logic [CNT_W-1:0] rd_row_q, rd_row_d;

    // Patch-row index on the read side locates the last row of the image.
    always_comb begin
        if (rd_fire_s && rd_last_s) begin
            rd_row_d = (rd_row_q == NPY_MAX) ? '0 : (rd_row_q + CNT_ONE);
        end else begin
            rd_row_d = rd_row_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_row_q <= '0;
        end else begin
            rd_row_q <= rd_row_d;
        end
    end

    always_comb begin
        data_out_last = rd_valid_s && rd_last_s && (rd_row_q == NPY_MAX);
    end
`endif

    patch_row_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .UNROLL_C   (UNROLL_C),
        .DEPTH      (ROW_BEATS),
        .AW         (AW)
    ) u_row_buffer (
        .clk_i      (clk),
        .we_i       (wr_fire_s),
        .wr_bank_i  (wr_bank_q),
        .wr_addr_i  (wr_addr_s),
        .wr_data_i  (data_in),
        .rd_bank_i  (rd_bank_q),
        .rd_addr_i  (rd_addr_q),
        .rd_data_o  (data_out)
    );

endmodule

// File: tb/tb_fixed_patch_unembed.sv
// Self-checking bench for fixed_patch_unembed: random pixels unpatchified by a software image model.
module tb_fixed_patch_unembed;

    localparam int DW        = 8;
    localparam int C         = 4;
    localparam int IMG_Y     = 8;
    localparam int IMG_X     = 8;
    localparam int P         = 2;
    localparam int U         = 2;
    localparam int CB        = C / U;
    localparam int NPX       = IMG_X / P;
    localparam int NPY       = IMG_Y / P;
    localparam int IMG_BEATS = IMG_Y * IMG_X * CB;
    localparam int BW        = DW * U;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in [U];
    logic          data_in_valid;
    logic          data_in_ready;
    logic [DW-1:0] data_out [U];
    logic          data_out_valid;
    logic          data_out_ready;
`ifdef PATCH_UNEMBED_LAST_EN
    logic          data_out_last;
`endif

    logic [BW-1:0] in_q [$];
    logic [BW-1:0] exp_q [$];
    int            vec_cnt = 0;
    int            err_cnt = 0;

    always #5 clk = ~clk;

    fixed_patch_unembed #(
        .DATA_WIDTH (DW),
        .C          (C),
        .IMG_Y      (IMG_Y),
        .IMG_X      (IMG_X),
        .PATCH      (P),
        .UNROLL_C   (U)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
`ifdef PATCH_UNEMBED_LAST_EN
        .data_out_last  (data_out_last),
`endif
        .data_out_ready (data_out_ready)
    );

    // Builds one image: the patch-major input stream and the raster stream it must turn into.
    task automatic gen_image(input bit pattern);
        int            pix [IMG_Y][IMG_X][C];
        logic [BW-1:0] beat;
        for (int y = 0; y < IMG_Y; y++)
            for (int x = 0; x < IMG_X; x++)
                for (int c = 0; c < C; c++)
                    pix[y][x][c] = pattern ? (((y / P) * NPX + x / P) * 16 + (y % P) * 8 + (x % P) * 4 + c)
                                           : int'($urandom_range(0, 255));
        for (int py = 0; py < NPY; py++)
            for (int px = 0; px < NPX; px++)
                for (int ky = 0; ky < P; ky++)
                    for (int kx = 0; kx < P; kx++)
                        for (int cb = 0; cb < CB; cb++) begin
                            beat = '0;
                            for (int e = 0; e < U; e++)
                                beat[e*DW +: DW] = DW'(pix[py*P+ky][px*P+kx][cb*U+e]);
                            in_q.push_back(beat);
                        end
        for (int y = 0; y < IMG_Y; y++)
            for (int x = 0; x < IMG_X; x++)
                for (int cb = 0; cb < CB; cb++) begin
                    beat = '0;
                    for (int e = 0; e < U; e++)
                        beat[e*DW +: DW] = DW'(pix[y][x][cb*U+e]);
                    exp_q.push_back(beat);
                end
    endtask

    // One clock: drive at posedge+1, sample at negedge, return at the next posedge+1.
    task automatic step(input bit dv, input bit dr, output bit inf, output bit outf,
                        output logic [BW-1:0] ob, output logic ir, output logic ov, output logic ol);
        logic [BW-1:0] hd;
        hd = (in_q.size() > 0) ? in_q[0] : '0;
        data_in_valid  = dv && (in_q.size() > 0);
        data_out_ready = dr;
        for (int e = 0; e < U; e++) data_in[e] = hd[e*DW +: DW];
        @(negedge clk);
        ir = data_in_ready;
        ov = data_out_valid;
        ob = '0;
        for (int e = 0; e < U; e++) ob[e*DW +: DW] = data_out[e];
`ifdef PATCH_UNEMBED_LAST_EN
        ol = data_out_last;
`else
        ol = 1'b0;
`endif
        inf  = data_in_valid && (ir === 1'b1);
        outf = (ov === 1'b1) && dr;
        if (inf) void'(in_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if (data_in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_in_ready: got %b expected 1", data_in_ready);
        end
        vec_cnt++;
        if (data_out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_out_valid: got %b expected 0", data_out_valid);
        end
    endtask

    task automatic test_elements();
        bit            inf, outf;
        logic          ir, ov, ol;
        logic [BW-1:0] ob, e, anchor;
        int            nout;
        nout = 0;
        gen_image(1'b1);
        for (int cyc = 0; cyc < 600 && exp_q.size() > 0; cyc++) begin
            step(1'b1, 1'b1, inf, outf, ob, ir, ov, ol);
            if (outf) begin
                e = exp_q.pop_front();
                vec_cnt++;
                if (ob !== e) begin
                    err_cnt++;
                    $display("FAIL elem_data beat %0d: got %h expected %h", nout, ob, e);
                end
                if (nout == 0 || nout == 2 || nout == 4) begin
                    anchor = (nout == 0) ? 16'h0100 : (nout == 2) ? 16'h0504 : 16'h1110;
                    vec_cnt++;
                    if (ob !== anchor) begin
                        err_cnt++;
                        $display("FAIL elem_anchor beat %0d: got %h expected %h", nout, ob, anchor);
                    end
                end
                nout++;
            end
        end
        vec_cnt++;
        if (nout != IMG_BEATS || in_q.size() != 0) begin
            err_cnt++;
            $display("FAIL elem_drain: got %0d beats out, %0d left in, expected %0d out, 0 left",
                     nout, in_q.size(), IMG_BEATS);
        end
    endtask

    task automatic test_random();
        bit            inf, outf, dr, hold;
        logic          ir, ov, ol, exp_last;
        logic [BW-1:0] ob, e, prev_ob;
        int            nout;
        nout    = 0;
        hold    = 1'b0;
        prev_ob = '0;
        for (int i = 0; i < 3; i++) gen_image(1'b0);
        for (int cyc = 0; cyc < 8000 && exp_q.size() > 0; cyc++) begin
            dr = ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 3) != 0), dr, inf, outf, ob, ir, ov, ol);
            if (hold) begin
                vec_cnt++;
                if (ov !== 1'b1 || ob !== prev_ob) begin
                    err_cnt++;
                    $display("FAIL rand_hold: got valid=%b data=%h expected valid=1 data=%h", ov, ob, prev_ob);
                end
            end
            hold    = (ov === 1'b1) && !dr;
            prev_ob = ob;
            if (outf) begin
                e = exp_q.pop_front();
                vec_cnt++;
                if (ob !== e) begin
                    err_cnt++;
                    $display("FAIL rand_data beat %0d: got %h expected %h", nout, ob, e);
                end
`ifdef PATCH_UNEMBED_LAST_EN
                exp_last = ((nout % IMG_BEATS) == IMG_BEATS - 1);
                vec_cnt++;
                if (ol !== exp_last) begin
                    err_cnt++;
                    $display("FAIL rand_last beat %0d: got %b expected %b", nout, ol, exp_last);
                end
`else
                exp_last = 1'b0;
`endif
                nout++;
            end
        end
        vec_cnt++;
        if (nout != 3 * IMG_BEATS || in_q.size() != 0) begin
            err_cnt++;
            $display("FAIL rand_drain: got %0d beats out, %0d left in, expected %0d out, 0 left",
                     nout, in_q.size(), 3 * IMG_BEATS);
        end
    endtask

    task automatic test_backpressure();
        bit            inf, outf, just_freed;
        logic          ir, ov, ol;
        logic [BW-1:0] ob, e;
        int            acc, nout, low_bad;
        acc = 0; nout = 0; low_bad = 0; just_freed = 1'b0;
        do_reset();
        gen_image(1'b0);
        for (int cyc = 0; cyc < 80; cyc++) begin
            step(1'b1, 1'b0, inf, outf, ob, ir, ov, ol);
            if (inf) acc++;
        end
        vec_cnt++;
        if (acc != 64) begin
            err_cnt++;
            $display("FAIL bp_accepted: got %0d expected 64", acc);
        end
        vec_cnt++;
        if (ir !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_in_ready_low: got %b expected 0", ir);
        end
        for (int cyc = 0; cyc < 1000 && exp_q.size() > 0; cyc++) begin
            step(1'b1, 1'b1, inf, outf, ob, ir, ov, ol);
            if (just_freed) begin
                vec_cnt++;
                if (ir !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL bp_in_ready_rise: got %b expected 1", ir);
                end
                just_freed = 1'b0;
            end
            if (outf) begin
                e = exp_q.pop_front();
                vec_cnt++;
                if (ob !== e) begin
                    err_cnt++;
                    $display("FAIL bp_data beat %0d: got %h expected %h", nout, ob, e);
                end
                nout++;
                if (nout <= 32 && ir !== 1'b0) low_bad++;
                if (nout == 32) just_freed = 1'b1;
            end
        end
        vec_cnt++;
        if (low_bad != 0) begin
            err_cnt++;
            $display("FAIL bp_in_ready_held: got %0d early-ready cycles expected 0", low_bad);
        end
        vec_cnt++;
        if (nout != IMG_BEATS || in_q.size() != 0) begin
            err_cnt++;
            $display("FAIL bp_drain: got %0d beats out, %0d left in, expected %0d out, 0 left",
                     nout, in_q.size(), IMG_BEATS);
        end
    endtask

    task automatic test_latency();
        bit            inf, outf, pending;
        logic          ir, ov, ol;
        logic [BW-1:0] ob, e;
        int            acc, nout, early_bad;
        acc = 0; nout = 0; early_bad = 0; pending = 1'b0;
        do_reset();
        gen_image(1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            step(1'b1, 1'b0, inf, outf, ob, ir, ov, ol);
            if (pending) begin
                vec_cnt++;
                if (ov !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL lat_valid_rise: got %b expected 1", ov);
                end
                pending = 1'b0;
            end
            if (acc < 32 && ov !== 1'b0) early_bad++;
            if (inf) begin
                acc++;
                if (acc == 32) pending = 1'b1;
            end
        end
        vec_cnt++;
        if (early_bad != 0) begin
            err_cnt++;
            $display("FAIL lat_valid_early: got %0d early-valid cycles expected 0", early_bad);
        end
        for (int cyc = 0; cyc < 2000 && exp_q.size() > 0; cyc++) begin
            step(1'b1, ($urandom_range(0, 1) != 0), inf, outf, ob, ir, ov, ol);
            if (outf) begin
                e = exp_q.pop_front();
                vec_cnt++;
                if (ob !== e) begin
                    err_cnt++;
                    $display("FAIL lat_data beat %0d: got %h expected %h", nout, ob, e);
                end
                nout++;
            end
        end
        vec_cnt++;
        if (nout != IMG_BEATS || in_q.size() != 0) begin
            err_cnt++;
            $display("FAIL lat_drain: got %0d beats out, %0d left in, expected %0d out, 0 left",
                     nout, in_q.size(), IMG_BEATS);
        end
    endtask

    task automatic test_reset_midrow();
        bit            inf, outf;
        logic          ir, ov, ol;
        logic [BW-1:0] ob;
        int            acc;
        acc = 0;
        do_reset();
        gen_image(1'b1);
        for (int cyc = 0; cyc < 100 && acc < 20; cyc++) begin
            step(1'b1, 1'b1, inf, outf, ob, ir, ov, ol);
            if (inf) acc++;
        end
        vec_cnt++;
        if (acc != 20) begin
            err_cnt++;
            $display("FAIL mid_accepted: got %0d expected 20", acc);
        end
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (data_out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_out_valid: got %b expected 0", data_out_valid);
        end
        vec_cnt++;
        if (data_in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_in_ready: got %b expected 1", data_in_ready);
        end
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        rst = 1'b1;
        in_q.delete();
        exp_q.delete();
        test_elements();
    endtask

    initial begin
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        for (int e = 0; e < U; e++) data_in[e] = '0;
        test_reset();
        test_elements();
        test_random();
        test_backpressure();
        test_latency();
        test_reset_midrow();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
